// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encodings,
//   the default operand width and a constant-foldable ceil(log2) helper used
//   to size the bit counter.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 32'sd8;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    for (int i = 0; i < 32; i++) begin
      if (v > 32'sd0) begin
        result = result + 32'sd1;
        v      = v >>> 1;
      end else begin
        v      = v;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   One-bit full subtractor: d = x - y - bi, with borrow-out bo.
//   Ports:
//     x, y  : minuend / subtrahend bits
//     bi    : borrow-in
//     d     : difference bit
//     bo    : borrow-out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub_8.sv
// serial_sub_8
//   Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
//   Operands are accepted with a valid/ready handshake in IDLE, processed over
//   WIDTH cycles in RUN, and presented in DONE until the consumer accepts.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid / in_ready : operand handshake
//     a, b, bin           : minuend, subtrahend, borrow-in
//     out_valid/out_ready : result handshake
//     diff                : a - b - bin modulo 2^WIDTH
//     bout, zero, ovf     : final borrow, diff==0, signed overflow
module serial_sub_8
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  // Holds the WIDTH-1 difference bits produced so far; the last bit comes
  // straight from the full subtractor when the result is loaded.
  logic [WIDTH-2:0] res_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             zero_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             d_s;
  logic             bo_s;
  logic             last_s;
  logic [WIDTH-1:0] full_s;

  full_subtractor u_fs (
    .x  (a_sh_r[0]),
    .y  (b_sh_r[0]),
    .bi (br_r),
    .d  (d_s),
    .bo (bo_s)
  );

  assign last_s = (cnt_r == LAST_BIT);
  assign full_s = {d_s, res_r};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_next_s = ST_RUN;
        else          state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_next_s = ST_DONE;
        else        state_next_s = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) state_next_s = ST_IDLE;
        else           state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state, then registered.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_next_s)
      ST_IDLE: in_ready_s  = 1'b1;
      ST_DONE: out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Operand capture, serial datapath and result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      br_r   <= 1'b0;
      a_sh_r <= {WIDTH{1'b0}};
      b_sh_r <= {WIDTH{1'b0}};
      res_r  <= {(WIDTH-1){1'b0}};
      diff_r <= {WIDTH{1'b0}};
      bout_r <= 1'b0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh_r <= a;
            b_sh_r <= b;
            br_r   <= bin;
            cnt_r  <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          a_sh_r <= a_sh_r >> 1;
          b_sh_r <= b_sh_r >> 1;
          br_r   <= bo_s;
          res_r  <= (WIDTH-1)'(full_s >> 1);
          if (last_s) begin
            // Operand MSBs sit at bit 0 of the shift registers here.
            diff_r <= full_s;
            bout_r <= bo_s;
            zero_r <= (full_s == {WIDTH{1'b0}});
            ovf_r  <= (a_sh_r[0] != b_sh_r[0]) && (d_s != a_sh_r[0]);
          end else begin
            cnt_r  <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_sub_8.sv
module tb_serial_sub_8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       zero;
  logic       ovf;

  int vectors;
  int miscompares;

  serial_sub_8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    tick(); tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 ||
        bout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b diff=%h b=%b z=%b o=%b, want 1 0 00 0 0 0",
               in_ready, out_valid, diff, bout, zero, ovf);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Start one operation, check latency and result, then hand the result off.
  task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tbin, input logic [7:0] ed, input logic eb,
                        input logic ez, input logic eo, input logic release_out);
    logic early;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready: in_ready=%b, want 1", name, in_ready);
    end
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = 8'hxx; b = 8'hxx; bin = 1'bx;
    early = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b0) early = 1'b1;
    end
    tick();
    vectors++;
    if (early || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_latency: early=%b out_valid=%b, want early=0 out_valid=1",
               name, early, out_valid);
    end
    vectors++;
    if (diff !== ed || bout !== eb || zero !== ez || ovf !== eo) begin
      miscompares++;
      $display("FAIL %s_result: diff=%h bout=%b zero=%b ovf=%b, want %h %b %b %b",
               name, diff, bout, zero, ovf, ed, eb, ez, eo);
    end
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_release: in_ready=%b out_valid=%b, want 1 0",
                 name, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_arith();
    run_op("simple",    8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("underflow", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("sovf",      8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op("bin_zero",  8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_op("wrap_zero", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    run_op("neg_ovf",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    logic bad;
    run_op("bp", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; a = 8'h00; b = 8'h00; bin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (diff !== 8'hFE || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    in_valid = 1'b0;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL bp_hold: diff=%h in_ready=%b out_valid=%b, want FE 0 1",
               diff, in_ready, out_valid);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    tick(); tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 8'hFE) begin
      miscompares++;
      $display("FAIL bp_ignored: out_valid=%b in_ready=%b diff=%h, want 0 1 FE",
               out_valid, in_ready, diff);
    end
  endtask

  task automatic test_reset_mid_op();
    a = 8'h55; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 ||
        bout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset: rdy=%b vld=%b diff=%h b=%b z=%b o=%b, want 1 0 00 0 0 0",
               in_ready, out_valid, diff, bout, zero, ovf);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_op("after_rst", 8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
